// File: rtl/alu_cmd_stage.sv
// Command FIFO, registered issue stage and result register around an external
// combinational ALU; results leave in order over valid/ready with sticky flags.
module alu_cmd_stage #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [3:0]                 in_op_i,
    input  logic [W-1:0]               in_a_i,
    input  logic [W-1:0]               in_b_i,
    output logic [W-1:0]               alu_a_o,
    output logic [W-1:0]               alu_b_o,
    output logic [3:0]                 alu_op_o,
    input  logic [W-1:0]               alu_y_i,
    input  logic                       alu_carry_i,
    input  logic                       alu_overflow_i,
    input  logic                       alu_zero_i,
    input  logic                       alu_negative_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [W-1:0]               out_y_o,
    output logic [3:0]                 out_op_o,
    output logic [4:0]                 out_flags_o,
    output logic [4:0]                 sticky_flags_o,
    input  logic                       sticky_clr_i,
    output logic [$clog2(DEPTH):0]     fifo_count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 4 + 2 * W;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [3:0]    OP_IDLE  = 4'hF;
    localparam logic [3:0]    OP_DIV   = 4'hD;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          issue_valid_q, issue_valid_d;
    logic [3:0]    issue_op_q, issue_op_d;
    logic [W-1:0]  issue_a_q, issue_a_d;
    logic [W-1:0]  issue_b_q, issue_b_d;

    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_y_q, out_y_d;
    logic [3:0]    out_op_q, out_op_d;
    logic [4:0]    out_flags_q, out_flags_d;
    logic [4:0]    sticky_q, sticky_d;

    logic          push;
    logic          pop;
    logic          adv;
    logic          fifo_nonempty;
    logic          divz;
    logic          out_hs;
    logic [EW-1:0] head;

    // in_ready comes from the registered count only, so a full FIFO refuses
    // a push even in a cycle where the issue stage pops.
    assign in_ready_o    = (count_q != FULL_CNT);
    assign fifo_nonempty = (count_q != '0);
    assign adv           = ~out_valid_q | out_ready_i;
    assign push          = in_valid_i & in_ready_o;
    assign pop           = adv & fifo_nonempty;
    assign head          = mem_q[rd_ptr_q];
    assign out_hs        = out_valid_q & out_ready_i;
    assign divz          = (issue_op_q == OP_DIV) && (issue_b_q == '0);

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_op_i, in_a_i, in_b_i};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_op_d    = issue_op_q;
        issue_a_d     = issue_a_q;
        issue_b_d     = issue_b_q;
        if (adv) begin
            if (fifo_nonempty) begin
                issue_valid_d = 1'b1;
                issue_op_d    = head[EW-1 -: 4];
                issue_a_d     = head[2*W-1 -: W];
                issue_b_d     = head[W-1:0];
            end else begin
                issue_valid_d = 1'b0;
                issue_op_d    = OP_IDLE;
                issue_a_d     = '0;
                issue_b_d     = '0;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        out_op_d    = out_op_q;
        out_flags_d = out_flags_q;
        if (adv) begin
            out_valid_d = issue_valid_q;
            if (issue_valid_q) begin
                out_y_d     = alu_y_i;
                out_op_d    = issue_op_q;
                out_flags_d = {divz, alu_carry_i, alu_overflow_i, alu_zero_i, alu_negative_i};
            end
        end
    end

    // A clear coinciding with a handshake keeps that result's flags.
    always_comb begin
        sticky_d = sticky_q;
        if (sticky_clr_i) begin
            sticky_d = out_hs ? out_flags_q : 5'b0;
        end else if (out_hs) begin
            sticky_d = sticky_q | out_flags_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            issue_valid_q <= 1'b0;
            issue_op_q    <= OP_IDLE;
            issue_a_q     <= '0;
            issue_b_q     <= '0;
            out_valid_q   <= 1'b0;
            out_y_q       <= '0;
            out_op_q      <= '0;
            out_flags_q   <= '0;
            sticky_q      <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            issue_valid_q <= issue_valid_d;
            issue_op_q    <= issue_op_d;
            issue_a_q     <= issue_a_d;
            issue_b_q     <= issue_b_d;
            out_valid_q   <= out_valid_d;
            out_y_q       <= out_y_d;
            out_op_q      <= out_op_d;
            out_flags_q   <= out_flags_d;
            sticky_q      <= sticky_d;
        end
    end

    assign alu_a_o        = issue_a_q;
    assign alu_b_o        = issue_b_q;
    assign alu_op_o       = issue_op_q;
    assign out_valid_o    = out_valid_q;
    assign out_y_o        = out_y_q;
    assign out_op_o       = out_op_q;
    assign out_flags_o    = out_flags_q;
    assign sticky_flags_o = sticky_q;
    assign fifo_count_o   = count_q;

endmodule

// File: tb/tb_alu_cmd_stage.sv
// Bench for alu_cmd_stage: behavioural ALU, queue-based result scoreboard,
// directed test-plan steps followed by a randomized phase.
module tb_alu_cmd_stage;

    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_MUL = 4'hC;
    localparam logic [3:0] OP_DIV = 4'hD;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [W-1:0]  in_a, in_b;
    logic [W-1:0]  alu_a, alu_b, alu_y;
    logic [3:0]    alu_op;
    logic          alu_carry, alu_overflow, alu_zero, alu_negative;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_y;
    logic [3:0]    out_op;
    logic [4:0]    out_flags;
    logic [4:0]    sticky_flags;
    logic          sticky_clr;
    logic [CW-1:0] fifo_count;

    always #5 clk = ~clk;

    alu_cmd_stage #(.W(W), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_op_i(in_op), .in_a_i(in_a), .in_b_i(in_b),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
        .alu_y_i(alu_y), .alu_carry_i(alu_carry), .alu_overflow_i(alu_overflow),
        .alu_zero_i(alu_zero), .alu_negative_i(alu_negative),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_y_o(out_y), .out_op_o(out_op), .out_flags_o(out_flags),
        .sticky_flags_o(sticky_flags), .sticky_clr_i(sticky_clr),
        .fifo_count_o(fifo_count)
    );

    // Behavioural ALU: returns {y, carry, overflow, zero, negative}.
    function automatic logic [W+3:0] alu_f(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W-1:0] y;
        logic         c, v;
        int           ia, ib, r;
        ia = int'(a);
        ib = int'(b);
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'h0: begin
                r = ia + ib;
                y = W'(r);
                c = (r > 255);
                v = (a[W-1] == b[W-1]) && (y[W-1] != a[W-1]);
            end
            4'h1: begin
                r = ia - ib;
                y = W'(r);
                c = (ia >= ib);
                v = (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]);
            end
            4'h2: y = a & b;
            4'h3: y = a | b;
            4'h4: y = a ^ b;
            4'h5: y = ~a;
            4'h6: y = W'(ia * 2);
            4'h7: y = W'(ia / 2);
            4'hC: y = W'(ia * ib);
            4'hD: y = (ib == 0) ? '0 : W'(ia / ib);
            default: y = a;
        endcase
        return {y, c, v, (y == '0), y[W-1]};
    endfunction

    always_comb {alu_y, alu_carry, alu_overflow, alu_zero, alu_negative} = alu_f(alu_op, alu_a, alu_b);

    typedef struct packed {
        logic [3:0]   op;
        logic [W-1:0] y;
        logic [4:0]   flags;
    } exp_t;

    exp_t exp_q[$];
    logic [4:0] sticky_m;
    logic       accepted;
    int         checks = 0;
    int         errors = 0;
    logic [3:0] ops [11];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W+3:0] r;
        exp_t e;
        r = alu_f(op, a, b);
        e.op    = op;
        e.y     = r[W+3:4];
        e.flags = {(op == OP_DIV) && (b == '0), r[3:0]};
        return e;
    endfunction

    // One clock: sample at the negedge, update the model, check sticky after the edge.
    task automatic tick();
        exp_t e;
        logic hs;
        hs = 1'b0;
        e  = '0;
        @(negedge clk);
        accepted = in_valid && in_ready;
        if (out_valid && out_ready) begin
            hs = 1'b1;
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'(out_y), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("result_y", 32'(out_y), 32'(e.y));
                chk("result_op", 32'(out_op), 32'(e.op));
                chk("result_flags", 32'(out_flags), 32'(e.flags));
            end
        end
        if (sticky_clr)
            sticky_m = hs ? e.flags : 5'b0;
        else if (hs)
            sticky_m = sticky_m | e.flags;
        if (accepted)
            exp_q.push_back(model(in_op, in_a, in_b));
        @(posedge clk);
        #1;
        chk("sticky", 32'(sticky_flags), 32'(sticky_m));
    endtask

    task automatic push_cmd(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int k;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        k = 0;
        accepted = 1'b0;
        while (!accepted && k < 50) begin
            tick();
            k++;
        end
        if (!accepted) chk("push_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int k;
        k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        chk("wait_out_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 100) begin
            tick();
            k++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hC, 4'hD, 4'hF};
        rst = 1'b1;
        in_valid = 1'b1;
        in_op = OP_ADD;
        in_a = 8'h11;
        in_b = 8'h22;
        out_ready = 1'b1;
        sticky_clr = 1'b0;
        sticky_m = '0;
        accepted = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_sticky", 32'(sticky_flags), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'hF);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_out_y", 32'(out_y), 32'd0);
        in_valid = 1'b0;
        rst = 1'b0;

        // Latency: accept edge t, issue at t+1, out_valid after t+2.
        push_cmd(OP_ADD, 8'h7F, 8'h01);
        chk("lat_t0_out_valid", 32'(out_valid), 32'd0);
        tick();
        chk("lat_t1_out_valid", 32'(out_valid), 32'd0);
        chk("lat_t1_alu_op", 32'(alu_op), 32'(OP_ADD));
        chk("lat_t1_alu_a", 32'(alu_a), 32'h7F);
        tick();
        chk("lat_t2_out_valid", 32'(out_valid), 32'd1);
        chk("add_y", 32'(out_y), 32'h80);
        chk("add_flags", 32'(out_flags), 32'b00101);
        drain();

        push_cmd(OP_SUB, 8'h05, 8'h05);
        wait_out();
        chk("sub_eq_y", 32'(out_y), 32'h00);
        chk("sub_eq_flags", 32'(out_flags), 32'b01010);
        drain();
        push_cmd(OP_SUB, 8'h00, 8'h01);
        wait_out();
        chk("sub_borrow_y", 32'(out_y), 32'hFF);
        chk("sub_borrow_flags", 32'(out_flags), 32'b00001);
        drain();

        // Capacity: DEPTH + 2 accepts with out_ready low.
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) push_cmd(OP_ADD, W'(i), W'(i));
        chk("cap_in_ready", 32'(in_ready), 32'd0);
        chk("cap_fifo_count", 32'(fifo_count), 32'd4);
        in_op = OP_ADD;
        in_a = 8'd7;
        in_b = 8'd7;
        in_valid = 1'b1;
        tick();
        chk("cap_no_accept", 32'(accepted), 32'd0);
        tick();
        out_ready = 1'b1;
        push_cmd(OP_ADD, 8'd7, 8'd7);
        push_cmd(OP_ADD, 8'd8, 8'd8);
        drain();

        push_cmd(OP_DIV, 8'h10, 8'h00);
        wait_out();
        chk("divz_y", 32'(out_y), 32'h00);
        chk("divz_flags", 32'(out_flags), 32'b10010);
        tick();
        chk("divz_sticky", 32'(sticky_flags[4]), 32'd1);
        push_cmd(OP_DIV, 8'h10, 8'h04);
        wait_out();
        chk("div_y", 32'(out_y), 32'h04);
        chk("div_divz", 32'(out_flags[4]), 32'd0);
        tick();
        chk("div_sticky_kept", 32'(sticky_flags[4]), 32'd1);
        drain();

        push_cmd(OP_MUL, 8'h10, 8'h10);
        wait_out();
        sticky_clr = 1'b1;
        tick();
        chk("clr_with_hs", 32'(sticky_flags), 32'b00010);
        tick();
        chk("clr_alone", 32'(sticky_flags), 32'b00000);
        sticky_clr = 1'b0;

        // Randomized traffic checked by the scoreboard.
        for (int c = 0; c < 400; c++) begin
            in_valid   = ($urandom_range(0, 2) != 0);
            in_op      = ops[$urandom_range(0, 10)];
            in_a       = W'($urandom);
            in_b       = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
            sticky_clr = ($urandom_range(0, 15) == 0);
            tick();
            chk("rand_count_bound", 32'(fifo_count <= CW'(DEPTH)), 32'd1);
        end
        in_valid = 1'b0;
        sticky_clr = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset with 3 queued, one issued and one result pending.
        push_cmd(OP_ADD, 8'h40, 8'h40);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_cmd(OP_ADD, W'(i + 1), 8'h01);
        chk("pre_rst_count", 32'(fifo_count), 32'd3);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_count", 32'(fifo_count), 32'd0);
        chk("mid_rst_sticky", 32'(sticky_flags), 32'd0);
        exp_q.delete();
        sticky_m = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        push_cmd(OP_AND, 8'hF0, 8'h3C);
        wait_out();
        chk("post_rst_y", 32'(out_y), 32'h30);
        chk("post_rst_op", 32'(out_op), 32'(OP_AND));
        drain();
        repeat (5) tick();
        chk("post_rst_quiet", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_stage.md
Name: alu_cmd_stage

Overview:
- Sequential command front-end and result back-end wrapped around the combinational ALU (opcodes 0x0–0xF, W-bit operands, carry/overflow/zero/negative flags).
- Accepts {op, A, B} commands over a valid/ready interface and buffers them in a FIFO.
- Issues one command per cycle to the ALU from a registered issue stage, then captures Y and flags in a result register.
- Presents results downstream over valid/ready, in order, and keeps sticky status flags.

Parameters:
- W, 8, operand/result width; must match the ALU's W; W >= 2.
- DEPTH, 4, command FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  command present.
- in_ready  out  1  stage can accept a command.
- in_op  in  4  ALU opcode.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- alu_a  out  W  to ALU A.
- alu_b  out  W  to ALU B.
- alu_op  out  4  to ALU op.
- alu_y  in  W  from ALU Y.
- alu_carry  in  1  from ALU.
- alu_overflow  in  1  from ALU.
- alu_zero  in  1  from ALU.
- alu_negative  in  1  from ALU.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_y  out  W  result.
- out_op  out  4  opcode of the result.
- out_flags  out  5  {divz, carry, overflow, zero, negative}.
- sticky_flags  out  5  OR of out_flags over all consumed results.
- sticky_clr  in  1  clear sticky_flags.
- fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, rst=1):
  - FIFO pointers and count = 0; issue_valid = 0; out_valid = 0.
  - out_y, out_op, out_flags, sticky_flags = 0.
  - Issue registers = {op=4'hF, a=0, b=0}.
  - in_ready = 1 (FIFO not full). All inputs are ignored while rst=1.
  - Reset mid-operation discards all queued and in-flight commands; nothing is emitted afterwards for them.
- FIFO:
  - Push on in_valid & in_ready. Pop when the issue stage loads.
  - in_ready = (fifo_count != DEPTH), driven from registered count with no same-cycle pop credit; full FIFO means in_ready = 0 even if a pop occurs.
  - Simultaneous push and pop leaves count unchanged. Pointers wrap modulo DEPTH.
  - Data written into an empty FIFO is not visible to the issue stage until the next cycle; there is no bypass.
- Pipeline advance condition: adv = ~out_valid | out_ready.
- Issue stage:
  - When adv and issue_valid: capture the ALU outputs into the result register.
  - When adv and fifo non-empty: load the FIFO head into the issue registers and set issue_valid=1.
  - When adv and fifo empty: set issue_valid=0 and issue registers = {4'hF, 0, 0}.
  - When ~adv: issue registers and issue_valid hold.
  - alu_a, alu_b, alu_op are driven directly from the issue registers.
- Result stage:
  - out_valid <= issue_valid whenever adv.
  - On capture: out_y=alu_y, out_op=issue op, and the four ALU flags are copied into out_flags.
  - divz = (issue op == 4'hD) & (issue b == 0); the ALU already returns Y=0 in that case.
  - out_* hold stable while out_valid & ~out_ready.
- Latency: command accepted at edge t into an empty stage -> issued at edge t+1 -> out_valid=1 after edge t+2. Full throughput is 1 result/cycle with out_ready=1.
- Capacity: DEPTH + 2 commands (FIFO + issue + result) are accepted before in_ready falls while out_ready=0.
- Ordering: results leave strictly in command order; none are dropped or duplicated.
- Sticky flags:
  - On each out handshake (out_valid & out_ready): sticky_flags |= out_flags.
  - sticky_clr=1: sticky_flags <= 0, except that on the same cycle as a handshake, sticky_flags <= out_flags of that result (clear, then set).

Test Plan:
- Reset, then push ADD a=0x7F b=0x01 with out_ready=1 -> out_valid exactly 2 cycles after the accept edge; out_y=0x80, out_flags=5'b00101 (overflow=1, negative=1, carry=0, zero=0).
- Push SUB a=0x05 b=0x05 -> out_y=0x00, out_flags=5'b01010 (carry=1, i.e. no borrow; zero=1). Then SUB 0x00-0x01 -> out_y=0xFF, carry=0, negative=1.
- Hold out_ready=0 and offer 8 commands (ADD i,i for i=1..8) -> in_ready falls after the 6th accept, fifo_count=4. Raise out_ready -> results 0x02,0x04,…,0x0C in order; commands 7 and 8 are then accepted and produce 0x0E, 0x10.
- DIV a=0x10 b=0x00 -> out_y=0x00, divz=1, zero=1. After the handshake sticky_flags[4]=1; DIV 0x10/0x04 -> out_y=0x04, divz=0, sticky divz remains 1.
- Assert sticky_clr on the same cycle as consuming a MUL 0x10*0x10 result (out_y=0x00, zero=1) -> sticky_flags=5'b00010 next cycle. A lone sticky_clr -> sticky_flags=0.
- Assert rst with 3 queued commands and one result pending -> immediately out_valid=0, fifo_count=0, sticky=0. After release, a new AND 0xF0&0x3C -> out_y=0x30 as the first output.
